// File: rtl/ras_ckpt_stack_pkg.sv
// Shared fetch-unit types for the checkpointed return address stack:
// default geometry, pointer/occupancy types, checkpoint record and replay opcodes.
package ras_ckpt_stack_pkg;

  localparam int RAS_DEPTH = 16;

  typedef logic [$clog2(RAS_DEPTH)-1:0] RAS_IndexPath;
  typedef logic [$clog2(RAS_DEPTH):0]   RAS_CountPath;

  typedef struct packed {
    RAS_IndexPath topPtr;
    logic [31:0]  topData;
    RAS_CountPath count;
  } RAS_CheckpointData;

  typedef enum logic [1:0] {
    RAS_NONE = 2'd0,
    RAS_PUSH = 2'd1,
    RAS_POP  = 2'd2
  } RAS_ReplayOp;

  typedef enum logic {
    RAS_OVF_WRAP = 1'b0,
    RAS_OVF_DROP = 1'b1
  } RAS_OverflowMode;

endpackage

// File: rtl/ras_ckpt_stack_lane_select.sv
// Priority encoder picking the lowest fetch lane carrying a call or return.
// A lane flagged as both call and return is reported as a call.
module ras_lane_select #(
  parameter int FETCH_WIDTH = 2,
  parameter int SEL_W       = 1
) (
  input  logic [FETCH_WIDTH-1:0] i_valid,
  input  logic [FETCH_WIDTH-1:0] i_hit,
  input  logic [FETCH_WIDTH-1:0] i_push,
  input  logic [FETCH_WIDTH-1:0] i_pop,
  output logic [SEL_W-1:0]       o_sel,
  output logic                   o_sel_valid,
  output logic                   o_sel_push,
  output logic                   o_sel_pop
);
  import ras_ckpt_stack_pkg::*;

  logic [FETCH_WIDTH-1:0] w_cand;
  assign w_cand = i_valid & i_hit & (i_push | i_pop);

  // Scan from the top so the lowest candidate lane is the last one written.
  always_comb begin
    o_sel       = '0;
    o_sel_valid = 1'b0;
    o_sel_push  = 1'b0;
    o_sel_pop   = 1'b0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        o_sel       = SEL_W'(i);
        o_sel_valid = 1'b1;
        o_sel_push  = i_push[i];
        o_sel_pop   = ~i_push[i];
      end
    end
  end

endmodule

// File: rtl/ras_ckpt_stack.sv
// Checkpointed return address stack: multi-lane fetch push/pop, per-lane
// checkpoints, single-edge recovery with replay, saturating underflow counter.
module ras_ckpt_stack #(
  parameter int FETCH_WIDTH   = 2,
  parameter int RAS_DEPTH     = 16,
  parameter int PC_W          = 32,
  parameter int INSN_BYTES    = 4,
  parameter int OVERFLOW_MODE = 0,
  parameter int EVT_W         = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        stall,
  input  logic [FETCH_WIDTH-1:0]                      fetchValid,
  input  logic [FETCH_WIDTH*PC_W-1:0]                 fetchPC,
  input  logic [FETCH_WIDTH-1:0]                      btbHit,
  input  logic [FETCH_WIDTH-1:0]                      isPush,
  input  logic [FETCH_WIDTH-1:0]                      isPop,
  output logic [FETCH_WIDTH*PC_W-1:0]                 rasOut,
  output logic [FETCH_WIDTH-1:0]                      rasOutValid,
  output logic [FETCH_WIDTH*$clog2(RAS_DEPTH)-1:0]    ckptTopPtr,
  output logic [FETCH_WIDTH*PC_W-1:0]                 ckptTopData,
  output logic [FETCH_WIDTH*($clog2(RAS_DEPTH)+1)-1:0] ckptCount,
  input  logic                                        recover,
  input  logic [$clog2(RAS_DEPTH)-1:0]                recoverTopPtr,
  input  logic [PC_W-1:0]                             recoverTopData,
  input  logic [$clog2(RAS_DEPTH):0]                  recoverCount,
  input  logic [1:0]                                  recoverOp,
  input  logic [PC_W-1:0]                             recoverPC,
  output logic [EVT_W-1:0]                            underflowEvents
);
  import ras_ckpt_stack_pkg::*;

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int CW = IW + 1;
  localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam bit DROP_ON_FULL = (OVERFLOW_MODE == int'(RAS_OVF_DROP));

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [IW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic [EVT_W-1:0] r_uf;

  logic [SW-1:0]   w_sel;
  logic            w_sel_valid, w_sel_push, w_sel_pop;
  logic [PC_W-1:0] w_sel_pc;

  ras_lane_select #(.FETCH_WIDTH(FETCH_WIDTH), .SEL_W(SW)) u_sel (
    .i_valid    (fetchValid),
    .i_hit      (btbHit),
    .i_push     (isPush),
    .i_pop      (isPop),
    .o_sel      (w_sel),
    .o_sel_valid(w_sel_valid),
    .o_sel_push (w_sel_push),
    .o_sel_pop  (w_sel_pop)
  );

  always_comb begin
    w_sel_pc = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_sel == SW'(i)) w_sel_pc = fetchPC[i*PC_W +: PC_W];
    end
  end

  logic [IW-1:0]   w_base_top, w_top_next, w_addr0, w_addr1;
  logic [CW-1:0]   w_base_cnt, w_cnt_next;
  logic [PC_W-1:0] w_data0, w_data1, w_op_pc;
  logic            w_we0, w_we1, w_op_push, w_op_pop, w_uf_inc;

  // Recovery and fetch both reduce to "base state + one op"; recovery also restores the top.
  always_comb begin
    w_base_top = r_top;
    w_base_cnt = r_count;
    w_op_push  = 1'b0;
    w_op_pop   = 1'b0;
    w_op_pc    = w_sel_pc;
    w_we0      = 1'b0;
    w_addr0    = recoverTopPtr;
    w_data0    = recoverTopData;
    if (recover) begin
      w_base_top = recoverTopPtr;
      w_base_cnt = (recoverCount > FULL) ? FULL : recoverCount;
      w_we0      = 1'b1;
      w_op_push  = (recoverOp == RAS_PUSH);
      w_op_pop   = (recoverOp == RAS_POP);
      w_op_pc    = recoverPC;
    end else if (!stall && w_sel_valid) begin
      w_op_push  = w_sel_push;
      w_op_pop   = w_sel_pop;
    end

    w_top_next = w_base_top;
    w_cnt_next = w_base_cnt;
    w_we1      = 1'b0;
    w_addr1    = w_base_top + IW'(1);
    w_data1    = w_op_pc + PC_W'(INSN_BYTES);
    w_uf_inc   = 1'b0;
    if (w_op_push && !(DROP_ON_FULL && w_base_cnt == FULL)) begin
      w_we1      = 1'b1;
      w_top_next = w_base_top + IW'(1);
      w_cnt_next = (w_base_cnt == FULL) ? FULL : w_base_cnt + CW'(1);
    end else if (w_op_pop) begin
      if (w_base_cnt != '0) begin
        w_top_next = w_base_top - IW'(1);
        w_cnt_next = w_base_cnt - CW'(1);
      end else begin
        w_uf_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
      r_top   <= '0;
      r_count <= '0;
      r_uf    <= '0;
    end else begin
      if (w_we0) r_mem[w_addr0] <= w_data0;
      if (w_we1) r_mem[w_addr1] <= w_data1;
      r_top   <= w_top_next;
      r_count <= w_cnt_next;
      if (w_uf_inc && r_uf != '1) r_uf <= r_uf + EVT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
      assign rasOut[gi*PC_W +: PC_W]      = r_mem[r_top];
      assign rasOutValid[gi]              = (r_count != '0);
      assign ckptTopPtr[gi*IW +: IW]      = r_top;
      assign ckptTopData[gi*PC_W +: PC_W] = r_mem[r_top];
      assign ckptCount[gi*CW +: CW]       = r_count;
    end
  endgenerate

  assign underflowEvents = r_uf;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Randomised and directed bench for ras_ckpt_stack; a wrap-mode and a drop-mode
// instance share stimulus and are each compared with a simple stack model.
module tb_ras_ckpt_stack;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, recover;
  logic [1:0]  fv, bh, ip, iq, r_op;
  logic [63:0] fpc;
  logic [3:0]  r_tp;
  logic [31:0] r_td, r_pc;
  logic [4:0]  r_cnt;

  logic [63:0] ras   [2];
  logic [1:0]  rval  [2];
  logic [7:0]  cptr  [2];
  logic [63:0] cdata [2];
  logic [9:0]  ccnt  [2];
  logic [15:0] uf    [2];

  int checks = 0;
  int errors = 0;

  int unsigned m_mem [2][16];
  int m_top [2];
  int m_cnt [2];
  int m_uf  [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ras_ckpt_stack #(.OVERFLOW_MODE(gi)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .fetchValid(fv), .fetchPC(fpc), .btbHit(bh), .isPush(ip), .isPop(iq),
      .rasOut(ras[gi]), .rasOutValid(rval[gi]), .ckptTopPtr(cptr[gi]),
      .ckptTopData(cdata[gi]), .ckptCount(ccnt[gi]),
      .recover(recover), .recoverTopPtr(r_tp), .recoverTopData(r_td),
      .recoverCount(r_cnt), .recoverOp(r_op), .recoverPC(r_pc),
      .underflowEvents(uf[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 16; k++) m_mem[m][k] = 0;
      m_top[m] = 0; m_cnt[m] = 0; m_uf[m] = 0;
    end
  endtask

  // op: 0 none, 1 push, 2 pop
  task automatic model_op(input int m, input int op, input int unsigned pc);
    if (op == 1) begin
      if (!(m == 1 && m_cnt[m] == 16)) begin
        m_top[m] = (m_top[m] + 1) % 16;
        m_mem[m][m_top[m]] = pc + 4;
        if (m_cnt[m] < 16) m_cnt[m]++;
      end
    end else if (op == 2) begin
      if (m_cnt[m] > 0) begin
        m_top[m] = (m_top[m] + 15) % 16;
        m_cnt[m]--;
      end else if (m_uf[m] < 65535) begin
        m_uf[m]++;
      end
    end
  endtask

  task automatic model_edge();
    int lane;
    for (int m = 0; m < 2; m++) begin
      if (recover) begin
        m_top[m] = int'(r_tp);
        m_mem[m][r_tp] = r_td;
        m_cnt[m] = (int'(r_cnt) > 16) ? 16 : int'(r_cnt);
        model_op(m, (r_op == 2'd1) ? 1 : (r_op == 2'd2) ? 2 : 0, r_pc);
      end else if (!stall) begin
        lane = -1;
        for (int l = 1; l >= 0; l--)
          if (fv[l] && bh[l] && (ip[l] || iq[l])) lane = l;
        if (lane >= 0) model_op(m, ip[lane] ? 1 : 2, fpc[lane*32 +: 32]);
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 2; l++) begin
        check($sformatf("%s.d%0d.l%0d.rasOut", tag, d, l), ras[d][l*32 +: 32], m_mem[d][m_top[d]]);
        check($sformatf("%s.d%0d.l%0d.valid", tag, d, l), rval[d][l], m_cnt[d] != 0);
        check($sformatf("%s.d%0d.l%0d.ptr", tag, d, l), cptr[d][l*4 +: 4], m_top[d]);
        check($sformatf("%s.d%0d.l%0d.data", tag, d, l), cdata[d][l*32 +: 32], m_mem[d][m_top[d]]);
        check($sformatf("%s.d%0d.l%0d.cnt", tag, d, l), ccnt[d][l*5 +: 5], m_cnt[d]);
      end
      check($sformatf("%s.d%0d.uf", tag, d), uf[d], m_uf[d]);
    end
  endtask

  task automatic idle();
    stall = 0; recover = 0; fv = 0; bh = 0; ip = 0; iq = 0; fpc = 0;
    r_tp = 0; r_td = 0; r_cnt = 0; r_op = 0; r_pc = 0;
  endtask

  // Called at a negedge with inputs already driven.
  task automatic cyc(input string tag);
    check_state(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    $display("cycle %s stall=%0b rec=%0b fv=%b push=%b pop=%b cnt0=%0d top0=%0d", tag,
             stall, recover, fv, ip, iq, m_cnt[0], m_top[0]);
    idle();
  endtask

  task automatic lane_op(input int lane, input bit push, input int unsigned pc);
    fv[lane] = 1; bh[lane] = 1;
    if (push) ip[lane] = 1; else iq[lane] = 1;
    fpc[lane*32 +: 32] = pc;
  endtask

  int saved_top;

  initial begin
    idle();
    model_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    check_state("reset");

    // asynchronous reset with a non-empty stack
    for (int k = 0; k < 5; k++) begin lane_op(0, 1, 32'h40 * k); cyc("fill5"); end
    check("fill5.cnt", ccnt[0][4:0], 5);
    rst = 1; #1;
    model_reset();
    check("arst.valid", rval[0], 0);
    check("arst.rasOut", ras[0], 0);
    check("arst.cnt", ccnt[1], 0);
    check("arst.uf", uf[0], 0);
    @(negedge clk); rst = 0;
    check_state("arst_hold");

    // push then pop
    lane_op(1, 1, 32'h1000); cyc("push1");
    check("push1.rasOut", ras[0], 64'h0000_1004_0000_1004);
    check("push1.cnt", ccnt[0][4:0], 1);
    check("push1.ptr", cptr[0][3:0], 1);
    lane_op(0, 0, 32'h2000); cyc("pop1");
    check("pop1.valid", rval[0], 0);
    check("pop1.cnt", ccnt[0][4:0], 0);

    // lane priority: lower lane pop beats upper lane push
    lane_op(0, 1, 32'h300); cyc("pri_a");
    lane_op(0, 1, 32'h400); cyc("pri_b");
    saved_top = m_top[0];
    lane_op(0, 0, 32'h500); lane_op(1, 1, 32'h600); cyc("pri");
    check("pri.cnt", ccnt[0][4:0], 1);
    check("pri.ptr", cptr[0][3:0], 4'((saved_top + 15) % 16));
    lane_op(0, 0, 0); cyc("drain");

    // overflow in both modes
    for (int k = 1; k <= 17; k++) begin lane_op(0, 1, 32'h100 * k); cyc("ovf"); end
    check("ovf.m0.cnt", ccnt[0][4:0], 16);
    check("ovf.m0.top", ras[0][31:0], 32'h1104);
    check("ovf.m1.top", ras[1][31:0], 32'h1004);
    for (int k = 0; k < 15; k++) begin lane_op(1, 0, 0); cyc("ovfpop"); end
    check("ovfpop.m0.top", ras[0][31:0], 32'h204);
    lane_op(0, 0, 0); cyc("ovf_empty");

    // underflow with one stalled pop
    saved_top = m_top[0];
    lane_op(0, 0, 0); cyc("uf1");
    lane_op(0, 0, 0); stall = 1; cyc("uf_stall");
    lane_op(1, 0, 0); cyc("uf2");
    check("uf.count", uf[0], 2);
    check("uf.ptr", cptr[0][3:0], 4'(saved_top));

    // recovery with push replay overrides a stalled pop
    recover = 1; r_tp = 3; r_td = 32'hA0; r_cnt = 4; r_op = 2'd1; r_pc = 32'hB00;
    lane_op(0, 0, 0); stall = 1; cyc("recover");
    check("rec.ptr", cptr[0][3:0], 4);
    check("rec.rasOut", ras[0][31:0], 32'hB04);
    check("rec.cnt", ccnt[0][4:0], 5);
    lane_op(0, 0, 0); cyc("rec_pop");
    check("rec.entry3", ras[0][31:0], 32'hA0);

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      fv = 2'($urandom); bh = 2'($urandom); ip = 2'($urandom); iq = 2'($urandom);
      fpc = {$urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0);
      recover = ($urandom_range(0, 7) == 0);
      r_tp = 4'($urandom); r_td = $urandom; r_cnt = 5'($urandom);
      r_op = 2'($urandom); r_pc = $urandom;
      cyc("rand");
    end
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
